// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, FSM states,
// mux/ALU select codes and the bundled control-output struct.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_AND   = 2'b11;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcEn;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       regDst;
    logic       memtoReg;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSource;
    logic       instrDone;
  } ctrl_t;

  function automatic logic op_known(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_J) || (op == OP_ADDI) || (op == OP_ANDI);
  endfunction

  function automatic logic [1:0] imm_aluop(input logic [5:0] op);
    return (op == OP_ANDI) ? ALU_AND : ALU_ADD;
  endfunction

endpackage

// File: rtl/mc_out_decode.sv
// Combinational control-output decode from current state; memReady and zero
// feed straight through so handshakes complete in the presenting cycle.
import mips_pkg::*;

module mc_out_decode (
  input  state_t     i_state,
  input  logic [5:0] i_opcode,
  input  logic       i_zero,
  input  logic       i_memReady,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.memRead = 1'b1;
        o_ctrl.aluSrcB = SRCB_FOUR;
        o_ctrl.irWrite = i_memReady;
        o_ctrl.pcEn    = i_memReady;
      end
      S_DECODE: begin
        o_ctrl.aluSrcB   = SRCB_IMMSH;
        o_ctrl.instrDone = ~op_known(i_opcode);
      end
      S_MEMADR: begin
        o_ctrl.aluSrcA = 1'b1;
        o_ctrl.aluSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        o_ctrl.memRead = 1'b1;
        o_ctrl.iorD    = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.regWrite  = 1'b1;
        o_ctrl.memtoReg  = 1'b1;
        o_ctrl.instrDone = 1'b1;
      end
      S_MEMWR: begin
        o_ctrl.memWrite  = 1'b1;
        o_ctrl.iorD      = 1'b1;
        o_ctrl.instrDone = i_memReady;
      end
      S_EXEC: begin
        o_ctrl.aluSrcA = 1'b1;
        o_ctrl.aluOp   = ALU_FUNCT;
      end
      S_ALUWB: begin
        o_ctrl.regWrite  = 1'b1;
        o_ctrl.regDst    = 1'b1;
        o_ctrl.instrDone = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.aluSrcA   = 1'b1;
        o_ctrl.aluOp     = ALU_SUB;
        o_ctrl.pcSource  = PC_ALUOUT;
        o_ctrl.pcEn      = i_zero;
        o_ctrl.instrDone = 1'b1;
      end
      S_JUMP: begin
        o_ctrl.pcSource  = PC_JUMP;
        o_ctrl.pcEn      = 1'b1;
        o_ctrl.instrDone = 1'b1;
      end
      S_IEXEC: begin
        o_ctrl.aluSrcA = 1'b1;
        o_ctrl.aluSrcB = SRCB_IMM;
        o_ctrl.aluOp   = imm_aluop(i_opcode);
      end
      S_IWB: begin
        o_ctrl.regWrite  = 1'b1;
        o_ctrl.aluOp     = imm_aluop(i_opcode);
        o_ctrl.instrDone = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: state register and next-state logic; outputs
// come from mc_out_decode and are forced low asynchronously while rst is high.
import mips_pkg::*;

module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       memReady,
  output logic       pcEn,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       regDst,
  output logic       memtoReg,
  output logic       regWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic [1:0] pcSource,
  output logic       instrDone,
  output logic [3:0] state
);

  state_t r_state;
  ctrl_t  w_ctrl;
  ctrl_t  w_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:  if (memReady) r_state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_RTYPE:        r_state <= S_EXEC;
            OP_LW, OP_SW:    r_state <= S_MEMADR;
            OP_BEQ:          r_state <= S_BRANCH;
            OP_J:            r_state <= S_JUMP;
            OP_ADDI, OP_ANDI: r_state <= S_IEXEC;
            default:         r_state <= S_FETCH;
          endcase
        end
        S_MEMADR: r_state <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (memReady) r_state <= S_MEMWB;
        S_MEMWR:  if (memReady) r_state <= S_FETCH;
        S_EXEC:   r_state <= S_ALUWB;
        S_IEXEC:  r_state <= S_IWB;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  mc_out_decode u_dec (
    .i_state    (r_state),
    .i_opcode   (opcode),
    .i_zero     (zero),
    .i_memReady (memReady),
    .o_ctrl     (w_ctrl)
  );

  // Gating on rst directly keeps strobes low even before the state register settles.
  assign w_out     = rst ? '0 : w_ctrl;
  assign pcEn      = w_out.pcEn;
  assign iorD      = w_out.iorD;
  assign memRead   = w_out.memRead;
  assign memWrite  = w_out.memWrite;
  assign irWrite   = w_out.irWrite;
  assign regDst    = w_out.regDst;
  assign memtoReg  = w_out.memtoReg;
  assign regWrite  = w_out.regWrite;
  assign aluSrcA   = w_out.aluSrcA;
  assign aluSrcB   = w_out.aluSrcB;
  assign aluOp     = w_out.aluOp;
  assign pcSource  = w_out.pcSource;
  assign instrDone = w_out.instrDone;
  assign state     = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle state and full output vector
// compared against hand-written expectations.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       memReady;
  logic       pcEn, iorD, memRead, memWrite, irWrite, regDst, memtoReg, regWrite, aluSrcA, instrDone;
  logic [1:0] aluSrcB, aluOp, pcSource;
  logic [3:0] state;
  logic [15:0] outs;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .memReady(memReady),
    .pcEn(pcEn), .iorD(iorD), .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite),
    .regDst(regDst), .memtoReg(memtoReg), .regWrite(regWrite), .aluSrcA(aluSrcA),
    .aluSrcB(aluSrcB), .aluOp(aluOp), .pcSource(pcSource), .instrDone(instrDone), .state(state)
  );

  assign outs = {pcEn, iorD, memRead, memWrite, irWrite, regDst, memtoReg, regWrite,
                 aluSrcA, aluSrcB, aluOp, pcSource, instrDone};

  // Builds an expected output vector in the same bit order as outs.
  function automatic logic [15:0] e(input logic pe, input logic io, input logic mr, input logic mw,
                                    input logic ir, input logic rd, input logic mtr, input logic rw,
                                    input logic sa, input logic [1:0] sb, input logic [1:0] op,
                                    input logic [1:0] ps, input logic dn);
    return {pe, io, mr, mw, ir, rd, mtr, rw, sa, sb, op, ps, dn};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; opcode = 6'b000000; zero = 1'b0; memReady = 1'b1;
    #2;
    checks++;
    if (state !== 4'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
    checks++;
    if (outs !== 16'h0) begin errors++; $display("FAIL reset_outs got %h want 0000", outs); end
    tick();
    checks++;
    if (outs !== 16'h0 || state !== 4'd0) begin
      errors++; $display("FAIL reset_hold outs=%h state=%0d want 0000/0", outs, state);
    end
    rst = 1'b0;
  endtask

  task automatic test_lw();
    logic [3:0]  es [5] = '{0, 1, 2, 3, 4};
    logic [15:0] eo [5];
    int done_cnt = 0;
    eo[0] = e(1,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0);
    eo[1] = e(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0);
    eo[2] = e(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
    eo[3] = e(0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0);
    eo[4] = e(0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,1);
    opcode = 6'b100011; memReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #2;
      done_cnt += int'(instrDone);
      checks++;
      if (state !== es[i]) begin errors++; $display("FAIL lw_state[%0d] got %0d want %0d", i, state, es[i]); end
      checks++;
      if (outs !== eo[i]) begin errors++; $display("FAIL lw_outs[%0d] got %h want %h", i, outs, eo[i]); end
      tick();
    end
    checks++;
    if (done_cnt != 1 || state !== 4'd0) begin
      errors++; $display("FAIL lw_end done_cnt=%0d state=%0d want 1/0", done_cnt, state);
    end
  endtask

  task automatic test_sw_wait();
    logic [3:0]  es [8] = '{0, 1, 2, 5, 5, 5, 5, 0};
    logic        mr [8] = '{1, 1, 1, 0, 0, 0, 1, 1};
    logic [15:0] eo [8];
    int mw_cnt = 0;
    eo[0] = e(1,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0);
    eo[1] = e(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0);
    eo[2] = e(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
    eo[3] = e(0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0);
    eo[4] = eo[3];
    eo[5] = eo[3];
    eo[6] = e(0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,1);
    eo[7] = eo[0];
    opcode = 6'b101011;
    for (int i = 0; i < 8; i++) begin
      memReady = mr[i];
      #2;
      mw_cnt += int'(memWrite);
      checks++;
      if (state !== es[i]) begin errors++; $display("FAIL sw_state[%0d] got %0d want %0d", i, state, es[i]); end
      checks++;
      if (outs !== eo[i]) begin errors++; $display("FAIL sw_outs[%0d] got %h want %h", i, outs, eo[i]); end
      if (i < 7) tick();
    end
    checks++;
    if (mw_cnt != 4) begin errors++; $display("FAIL sw_memwrite_cycles got %0d want 4", mw_cnt); end
    // finish the started fetch as a nop so the next test begins in FETCH
    opcode = 6'b111111;
    tick(); tick();
  endtask

  task automatic test_beq();
    logic [15:0] e8;
    for (int z = 1; z >= 0; z--) begin
      opcode = 6'b000100; memReady = 1'b1; zero = z[0];
      tick(); tick();
      #2;
      e8 = e(z[0],0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1);
      checks++;
      if (state !== 4'd8) begin errors++; $display("FAIL beq_state z=%0d got %0d want 8", z, state); end
      checks++;
      if (outs !== e8) begin errors++; $display("FAIL beq_outs z=%0d got %h want %h", z, outs, e8); end
      tick();
      checks++;
      if (state !== 4'd0) begin errors++; $display("FAIL beq_end z=%0d got %0d want 0", z, state); end
    end
    zero = 1'b0;
  endtask

  task automatic test_imm();
    logic [5:0] ops [2] = '{6'b001000, 6'b001100};
    logic [1:0] aop [2] = '{2'b00, 2'b11};
    logic [15:0] e10, e11;
    for (int k = 0; k < 2; k++) begin
      opcode = ops[k]; memReady = 1'b1;
      tick(); tick();
      #2;
      e10 = e(0,0,0,0,0,0,0,0,1,2'b10,aop[k],2'b00,0);
      checks++;
      if (state !== 4'd10 || outs !== e10) begin
        errors++; $display("FAIL iexec[%0d] state=%0d outs=%h want 10/%h", k, state, outs, e10);
      end
      tick();
      #2;
      e11 = e(0,0,0,0,0,0,0,1,0,2'b00,aop[k],2'b00,1);
      checks++;
      if (state !== 4'd11 || outs !== e11) begin
        errors++; $display("FAIL iwb[%0d] state=%0d outs=%h want 11/%h", k, state, outs, e11);
      end
      tick();
    end
  endtask

  task automatic test_rtype_jump();
    logic [15:0] ex, ew, ej;
    ex = e(0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0);
    ew = e(0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,1);
    ej = e(1,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1);
    opcode = 6'b000000; memReady = 1'b1;
    tick(); tick(); #2;
    checks++;
    if (state !== 4'd6 || outs !== ex) begin errors++; $display("FAIL exec state=%0d outs=%h want 6/%h", state, outs, ex); end
    tick(); #2;
    checks++;
    if (state !== 4'd7 || outs !== ew) begin errors++; $display("FAIL aluwb state=%0d outs=%h want 7/%h", state, outs, ew); end
    tick();
    opcode = 6'b000010;
    tick(); tick(); #2;
    checks++;
    if (state !== 4'd9 || outs !== ej) begin errors++; $display("FAIL jump state=%0d outs=%h want 9/%h", state, outs, ej); end
    tick();
  endtask

  task automatic test_unknown_and_fetch_wait();
    logic [15:0] ewait, ed;
    ewait = e(0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0);
    ed    = e(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,1);
    opcode = 6'b111111; memReady = 1'b0;
    #2;
    checks++;
    if (state !== 4'd0 || outs !== ewait) begin errors++; $display("FAIL fetch_wait state=%0d outs=%h want 0/%h", state, outs, ewait); end
    tick(); #2;
    checks++;
    if (state !== 4'd0) begin errors++; $display("FAIL fetch_hold got %0d want 0", state); end
    memReady = 1'b1;
    tick(); #2;
    checks++;
    if (state !== 4'd1 || outs !== ed) begin errors++; $display("FAIL unk_decode state=%0d outs=%h want 1/%h", state, outs, ed); end
    tick();
    checks++;
    if (state !== 4'd0) begin errors++; $display("FAIL unk_end got %0d want 0", state); end
  endtask

  task automatic test_reset_midwait();
    logic [15:0] ef;
    ef = e(1,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0);
    opcode = 6'b101011; memReady = 1'b1;
    tick(); tick(); tick();
    memReady = 1'b0;
    tick(); #2;
    checks++;
    if (state !== 4'd5 || memWrite !== 1'b1) begin errors++; $display("FAIL mw_wait state=%0d memWrite=%b want 5/1", state, memWrite); end
    rst = 1'b1;
    #1;
    checks++;
    if (memWrite !== 1'b0 || state !== 4'd0 || outs !== 16'h0) begin
      errors++; $display("FAIL async_rst memWrite=%b state=%0d outs=%h want 0/0/0000", memWrite, state, outs);
    end
    tick();
    rst = 1'b0; memReady = 1'b1; opcode = 6'b111111;
    #2;
    checks++;
    if (state !== 4'd0 || outs !== ef) begin errors++; $display("FAIL post_rst_fetch state=%0d outs=%h want 0/%h", state, outs, ef); end
    tick();
    checks++;
    if (state !== 4'd1) begin errors++; $display("FAIL post_rst_decode got %0d want 1", state); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_beq();
    test_imm();
    test_rtype_jump();
    test_unknown_and_fetch_wait();
    test_reset_midwait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
